// File: rtl/m_wbio_ctrl.sv
// Wishbone classic IO-bus controller: decodes one-hot slave selects inside the IO region,
// strobes the selected slaves, gathers their ACKs and ends dead or unmapped accesses with an error ACK.
module m_wbio_ctrl #(
  parameter int         NSLV     = 4,
  parameter logic [4:0] IOREGION = 5'b01100,
  parameter int         TIMEOUT  = 255
) (
  input  logic                 CLK_I,
  input  logic                 RST_N,
  input  logic                 m_CYC_I,
  input  logic                 m_STB_I,
  input  logic                 m_WE_I,
  input  logic [31:0]          m_ADR_I,
  input  logic [31:0]          m_DAT_I,
  input  logic [3:0]           m_SEL_I,
  output logic [31:0]          m_DAT_O,
  output logic                 m_ACK_O,
  output logic [NSLV-1:0]      s_STB_O,
  output logic                 s_WE_O,
  output logic [31:0]          s_ADR_O,
  output logic [31:0]          s_DAT_O,
  output logic [3:0]           s_SEL_O,
  input  logic [NSLV*32-1:0]   s_DAT_I,
  input  logic [NSLV-1:0]      s_ACK_I,
  output logic                 err_o,
  output logic [31:0]          err_adr_o
);

  localparam int CW = 12;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

  state_t          state, state_nxt;
  logic [NSLV-1:0] pending, pending_nxt;
  logic [NSLV-1:0] stb_nxt;
  logic [NSLV-1:0] mask, low_mask, busy_left;
  logic [CW-1:0]   count, count_nxt;
  logic            armed, armed_nxt;
  logic            ack_nxt, err_nxt, latch;
  logic [31:0]     dat_nxt, err_adr_nxt, rd_data;

  // A read's pending vector is one-hot, so it selects the returning slave directly.
  always_comb begin
    mask = '0;
    if (m_ADR_I[31:27] == IOREGION) mask = m_ADR_I[NSLV+1:2];
    low_mask  = mask & (~mask + NSLV'(1));
    busy_left = pending & ~s_ACK_I;
    rd_data   = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (pending[k]) rd_data = s_DAT_I[32*k +: 32];
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    stb_nxt     = s_STB_O;
    count_nxt   = count;
    ack_nxt     = 1'b0;
    err_nxt     = 1'b0;
    dat_nxt     = m_DAT_O;
    err_adr_nxt = err_adr_o;
    latch       = 1'b0;
    case (state)
      IDLE: begin
        if (m_CYC_I && m_STB_I && armed) begin
          latch     = 1'b1;
          count_nxt = '0;
          if (mask == '0) begin
            state_nxt   = ERR;
            ack_nxt     = 1'b1;
            err_nxt     = 1'b1;
            dat_nxt     = '0;
            err_adr_nxt = m_ADR_I;
            pending_nxt = '0;
            stb_nxt     = '0;
          end else begin
            state_nxt   = BUSY;
            pending_nxt = m_WE_I ? mask : low_mask;
            stb_nxt     = m_WE_I ? mask : low_mask;
          end
        end
      end
      BUSY: begin
        if (!m_CYC_I) begin
          state_nxt   = IDLE;
          pending_nxt = '0;
          stb_nxt     = '0;
        end else begin
          pending_nxt = busy_left;
          stb_nxt     = busy_left;
          if (!s_WE_O && ((pending & s_ACK_I) != '0)) dat_nxt = rd_data;
          // A final ACK arriving together with the timeout still completes normally.
          if (busy_left == '0) begin
            state_nxt = DONE;
            ack_nxt   = 1'b1;
          end else if (count == CNT_LAST) begin
            state_nxt   = ERR;
            ack_nxt     = 1'b1;
            err_nxt     = 1'b1;
            dat_nxt     = '0;
            err_adr_nxt = s_ADR_O;
            pending_nxt = '0;
            stb_nxt     = '0;
          end else if (count != CNT_MAX) begin
            count_nxt = count + 1'b1;
          end
        end
      end
      DONE, ERR: begin
        state_nxt   = IDLE;
        pending_nxt = '0;
        stb_nxt     = '0;
      end
      default: state_nxt = IDLE;
    endcase
    // A strobe still held during the ACK cycle must not launch a second access.
    armed_nxt = armed;
    if (m_ACK_O)       armed_nxt = 1'b0;
    else if (!m_STB_I) armed_nxt = 1'b1;
  end

  always_ff @(posedge CLK_I or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      pending   <= '0;
      count     <= '0;
      armed     <= 1'b0;
      s_STB_O   <= '0;
      m_ACK_O   <= 1'b0;
      err_o     <= 1'b0;
      m_DAT_O   <= '0;
      err_adr_o <= '0;
      s_WE_O    <= 1'b0;
      s_ADR_O   <= '0;
      s_DAT_O   <= '0;
      s_SEL_O   <= '0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      count     <= count_nxt;
      armed     <= armed_nxt;
      s_STB_O   <= stb_nxt;
      m_ACK_O   <= ack_nxt;
      err_o     <= err_nxt;
      m_DAT_O   <= dat_nxt;
      err_adr_o <= err_adr_nxt;
      if (latch) begin
        s_WE_O  <= m_WE_I;
        s_ADR_O <= m_ADR_I;
        s_DAT_O <= m_DAT_I;
        s_SEL_O <= m_SEL_I;
      end
    end
  end

endmodule
